connector_lane_collector: RTL and testbench

// Receive-side collector for the three-lane write connector (wen0..2 / data0..2).

---
 rtl/connector_lane_collector.sv | 142 ++++++++++++++
 tb/tb_connector_lane_collector.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/connector_lane_collector.sv
// Receive-side collector for the three-lane write connector: per-lane FIFOs merged
// into one valid/ready stream by round-robin arbitration, with sticky per-lane overflow.
module connector_lane_collector #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              wen0,
    input  logic [DATA_W-1:0] data0,
    input  logic              wen1,
    input  logic [DATA_W-1:0] data1,
    input  logic              wen2,
    input  logic [DATA_W-1:0] data2,
    input  logic              freeze,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        out_lane,
    output logic [2:0]        overflow,
    input  logic              clr_ovf
);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    logic [2:0]        wen;
    logic [DATA_W-1:0] wdata    [3];
    logic [DATA_W-1:0] mem      [3][FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr_q [3];
    logic [PW-1:0]     rd_ptr_q [3];
    logic [CW-1:0]     count_q  [3];

    logic [2:0]      nonempty, full, push, pop;
    logic [2:0][1:0] order;
    logic [1:0]      rr_q, rr_d, grant;
    logic            grant_valid, reg_free, load;

    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;
    logic [1:0]        out_lane_q;
    logic [2:0]        overflow_q, overflow_d;

    assign wen      = {wen2, wen1, wen0};
    assign wdata[0] = data0;
    assign wdata[1] = data1;
    assign wdata[2] = data2;

    // Fullness is judged on pre-edge occupancy, so a same-edge pop never rescues a write.
    always_comb begin
        nonempty = '0;
        full     = '0;
        push     = '0;
        for (int i = 0; i < 3; i++) begin
            nonempty[i] = (count_q[i] != '0);
            full[i]     = (count_q[i] == CW'(FIFO_DEPTH));
            push[i]     = wen[i] & ~full[i];
        end
    end

    // Search order starting at the round-robin pointer; order[0] is checked first.
    always_comb begin
        case (rr_q)
            2'd1:    order = {2'd0, 2'd2, 2'd1};
            2'd2:    order = {2'd1, 2'd0, 2'd2};
            default: order = {2'd2, 2'd1, 2'd0};
        endcase
        grant_valid = 1'b0;
        grant       = 2'd0;
        for (int k = 0; k < 3; k++) begin
            if (!grant_valid && nonempty[order[k]]) begin
                grant_valid = 1'b1;
                grant       = order[k];
            end
        end
    end

    always_comb begin
        reg_free   = ~out_valid_q | out_ready;
        load       = reg_free & ~freeze & grant_valid;
        pop        = load ? (3'b001 << grant) : 3'b000;
        rr_d       = load ? ((grant == 2'd2) ? 2'd0 : grant + 2'd1) : rr_q;
        overflow_d = (overflow_q & ~{3{clr_ovf}}) | (wen & full);
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (push[i]) begin
                mem[i][wr_ptr_q[i]] <= wdata[i];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 3; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                count_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (push[i]) begin
                    wr_ptr_q[i] <= wr_ptr_q[i] + PW'(1);
                end
                if (pop[i]) begin
                    rd_ptr_q[i] <= rd_ptr_q[i] + PW'(1);
                end
                case ({push[i], pop[i]})
                    2'b10:   count_q[i] <= count_q[i] + CW'(1);
                    2'b01:   count_q[i] <= count_q[i] - CW'(1);
                    default: count_q[i] <= count_q[i];
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_lane_q  <= 2'd0;
            overflow_q  <= 3'b000;
            rr_q        <= 2'd0;
        end else begin
            if (load) begin
                out_valid_q <= 1'b1;
                out_data_q  <= mem[grant][rd_ptr_q[grant]];
                out_lane_q  <= grant;
            end else if (reg_free) begin
                out_valid_q <= 1'b0;
            end
            overflow_q <= overflow_d;
            rr_q       <= rr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_lane  = out_lane_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_connector_lane_collector.sv
// Self-checking bench for connector_lane_collector: queue-based reference model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_connector_lane_collector;
    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          wen0 = 1'b0, wen1 = 1'b0, wen2 = 1'b0;
    logic [DW-1:0] data0 = '0, data1 = '0, data2 = '0;
    logic          freeze = 1'b0, out_ready = 1'b0, clr_ovf = 1'b0;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [1:0]    out_lane;
    logic [2:0]    overflow;

    always #5 clk = ~clk;

    connector_lane_collector #(
        .DATA_W     (DW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .wen0      (wen0),
        .data0     (data0),
        .wen1      (wen1),
        .data1     (data1),
        .wen2      (wen2),
        .data2     (data2),
        .freeze    (freeze),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_lane  (out_lane),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: one queue per lane plus the presented word.
    logic [DW-1:0] mq [3][$];
    logic          m_valid = 1'b0;
    logic [DW-1:0] m_data  = '0;
    int            m_lane  = 0;
    logic [2:0]    m_ovf   = 3'b000;
    int            m_ptr   = 0;

    always @(posedge clk) begin
        logic [2:0]    wv;
        logic [DW-1:0] dv [3];
        bit            fl [3];
        bit            free;
        int            g;
        int            l;
        wv    = {wen2, wen1, wen0};
        dv[0] = data0;
        dv[1] = data1;
        dv[2] = data2;
        if (!resetn) begin
            for (int i = 0; i < 3; i++) mq[i].delete();
            m_valid = 1'b0;
            m_data  = '0;
            m_lane  = 0;
            m_ovf   = 3'b000;
            m_ptr   = 0;
        end else begin
            for (int i = 0; i < 3; i++) fl[i] = (mq[i].size() >= DEPTH);
            free = !m_valid || out_ready;
            g = -1;
            if (free && !freeze) begin
                for (int k = 0; k < 3; k++) begin
                    l = (m_ptr + k) % 3;
                    if (g < 0 && mq[l].size() > 0) g = l;
                end
            end
            if (g >= 0) begin
                m_data  = mq[g].pop_front();
                m_lane  = g;
                m_valid = 1'b1;
                m_ptr   = (g + 1) % 3;
            end else if (free) begin
                m_valid = 1'b0;
            end
            if (clr_ovf) m_ovf = 3'b000;
            for (int i = 0; i < 3; i++) begin
                if (wv[i]) begin
                    if (fl[i]) m_ovf[i] = 1'b1;
                    else mq[i].push_back(dv[i]);
                end
            end
        end
        #1;
        chk("model out_valid", out_valid, m_valid);
        if (m_valid) begin
            chk("model out_data", out_data, m_data);
            chk("model out_lane", out_lane, m_lane);
        end
        chk("model overflow", overflow, m_ovf);
    end

    task automatic idle();
        wen0    = 1'b0;
        wen1    = 1'b0;
        wen2    = 1'b0;
        clr_ovf = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn    = 1'b0;
        idle();
        freeze    = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic word(input string name, input logic [DW-1:0] d, input int lane);
        chk({name, " valid"}, out_valid, 1'b1);
        chk({name, " data"}, out_data, d);
        chk({name, " lane"}, out_lane, lane);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("reset valid", out_valid, 1'b0);
        chk("reset data", out_data, 8'h00);
        chk("reset lane", out_lane, 2'd0);
        chk("reset ovf", overflow, 3'b000);
        resetn = 1'b1;

        // Single word latency
        wen1 = 1'b1; data1 = 8'hA5; out_ready = 1'b1;
        @(negedge clk); idle();
        chk("single early", out_valid, 1'b0);
        @(negedge clk); word("single", 8'hA5, 1);
        @(negedge clk); chk("single drained", out_valid, 1'b0);

        // Round-robin
        do_reset();
        out_ready = 1'b1;
        wen0 = 1'b1; data0 = 8'h10; wen1 = 1'b1; data1 = 8'h20; wen2 = 1'b1; data2 = 8'h30;
        @(negedge clk); idle();
        @(negedge clk); word("rr0", 8'h10, 0);
        @(negedge clk); word("rr1", 8'h20, 1);
        @(negedge clk); word("rr2", 8'h30, 2);
        wen0 = 1'b1; data0 = 8'h40; wen2 = 1'b1; data2 = 8'h50;
        @(negedge clk); idle();
        @(negedge clk); word("rr3", 8'h40, 0);
        @(negedge clk); word("rr4", 8'h50, 2);

        // Overflow on lane 0
        do_reset();
        for (int i = 1; i <= 6; i++) begin
            wen0 = 1'b1; data0 = 8'(i);
            @(negedge clk);
        end
        idle();
        chk("ovf flag", overflow, 3'b001);
        word("ovf head", 8'h01, 0);
        out_ready = 1'b1;
        for (int i = 2; i <= 5; i++) begin
            @(negedge clk);
            word("ovf drain", 8'(i), 0);
        end
        @(negedge clk); chk("ovf empty", out_valid, 1'b0);
        chk("ovf sticky", overflow, 3'b001);
        clr_ovf = 1'b1;
        @(negedge clk); idle();
        chk("ovf clear", overflow, 3'b000);

        // Freeze
        do_reset();
        wen2 = 1'b1; data2 = 8'h77;
        @(negedge clk); idle();
        @(negedge clk); word("frz held", 8'h77, 2);
        freeze = 1'b1; out_ready = 1'b1; wen0 = 1'b1; data0 = 8'h11;
        @(negedge clk); idle();
        chk("frz accept", out_valid, 1'b0);
        wen1 = 1'b1; data1 = 8'h22;
        @(negedge clk); idle();
        chk("frz hold", out_valid, 1'b0);
        freeze = 1'b0;
        @(negedge clk); word("frz r0", 8'h11, 0);
        @(negedge clk); word("frz r1", 8'h22, 1);
        @(negedge clk); chk("frz done", out_valid, 1'b0);

        // Asynchronous reset mid-stream
        do_reset();
        wen0 = 1'b1; data0 = 8'hA1; wen1 = 1'b1; data1 = 8'hA2; wen2 = 1'b1; data2 = 8'hA3;
        @(negedge clk);
        wen1 = 1'b0; wen2 = 1'b0; data0 = 8'hA4;
        @(negedge clk); idle();
        word("pre-rst", 8'hA1, 0);
        #2 resetn = 1'b0;
        #1;
        chk("arst valid", out_valid, 1'b0);
        chk("arst data", out_data, 8'h00);
        chk("arst lane", out_lane, 2'd0);
        chk("arst ovf", overflow, 3'b000);
        @(negedge clk);
        resetn = 1'b1; out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("arst silent", out_valid, 1'b0);
        end
        wen0 = 1'b1; data0 = 8'hC0; wen2 = 1'b1; data2 = 8'hC2;
        @(negedge clk); idle();
        @(negedge clk); word("arst p0", 8'hC0, 0);
        @(negedge clk); word("arst p2", 8'hC2, 2);

        // Randomized traffic with backpressure, freeze and clears
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            int rbias;
            rbias     = (c / 150) % 3;
            wen0      = 1'($urandom_range(0, 1));
            wen1      = 1'($urandom_range(0, 1));
            wen2      = 1'($urandom_range(0, 1));
            data0     = 8'($urandom);
            data1     = 8'($urandom);
            data2     = 8'($urandom);
            out_ready = (rbias == 0) ? 1'b1 : (rbias == 1) ? 1'($urandom_range(0, 1))
                                                         : ($urandom_range(0, 7) == 0);
            freeze    = ($urandom_range(0, 9) == 0);
            clr_ovf   = ($urandom_range(0, 40) == 0);
            @(negedge clk);
        end
        idle();
        freeze = 1'b0; out_ready = 1'b1;
        repeat (20) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
